paula_uart_sched: RTL

Register-bus scheduler for the Paula UART. Sits between the chipset register bus and the UART register port, sharing that port between CPU accesses and an internal engine. The engine programs SERPER, feeds bytes from a small TX FIFO into SERDAT when TBE is set, and drains received bytes from SERDATR on every receive interrupt. It presents a byte-stream valid/ready interface to a host/debug bridge.

---
 rtl/paula_uart_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/paula_uart_sched.sv
// Shares the Paula UART register port between CPU accesses and an engine that
// programs SERPER, feeds SERDAT from a TX FIFO and drains SERDATR on receive.
module paula_uart_sched #(
  parameter int          FIFO_DEPTH = 4,
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [15:0] INIT_PER   = 16'h001D
) (
  input  logic        clk,
  input  logic        clk7_en,
  input  logic        reset,
  input  logic [7:0]  cpu_rga_i,
  input  logic [15:0] cpu_data_i,
  output logic [7:0]  uart_rga_o,
  output logic [15:0] uart_data_o,
  input  logic [15:0] uart_data_i,
  input  logic        rxint,
  input  logic        per_wr,
  input  logic [15:0] per_val,
  input  logic [7:0]  tx_byte,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rbf_clr,
  output logic        rx_overflow,
  output logic        per_busy,
  output logic [2:0]  dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [7:0] RGA_SERDATR = 8'h0C;
  localparam logic [7:0] RGA_SERDAT  = 8'h18;
  localparam logic [7:0] RGA_SERPER  = 8'h19;
  localparam logic [7:0] RGA_IDLE    = 8'hFF;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WRPER, S_RXRD, S_RXCLR, S_POLL, S_WRDAT
  } state_t;

  // Handshakes: a byte moves on tx/rx only in a cycle where clk7_en, valid
  // and ready are all high; valid never waits on ready.

  state_t          state, state_nxt;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            rx_pend, per_pend;
  logic [15:0]     per_reg;
  logic [7:0]      eng_rga;
  logic [15:0]     eng_data;
  logic            cpu_idle, grant, full, push, pop;
  logic            rx_take, rx_consume, rx_accept, per_done;
  logic            unused_data_bits;

  assign cpu_idle    = (cpu_rga_i == RGA_IDLE);
  assign grant       = clk7_en & cpu_idle;
  assign uart_rga_o  = cpu_idle ? eng_rga  : cpu_rga_i;
  assign uart_data_o = cpu_idle ? eng_data : cpu_data_i;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign tx_ready   = ~full;
  assign push       = clk7_en & tx_valid & ~full;
  assign pop        = grant & (state == S_WRDAT);
  assign rx_take    = grant & (state == S_RXRD);
  assign per_done   = grant & (state == S_WRPER);
  assign rx_consume = clk7_en & rx_valid & rx_ready;
  assign rx_accept  = ~rx_valid | rx_consume;

  assign per_busy  = per_pend;
  assign dbg_state = state;

  assign unused_data_bits = ^{uart_data_i[15:14], uart_data_i[12:8]};

  always_comb begin
    state_nxt = state;
    eng_rga   = RGA_IDLE;
    eng_data  = 16'h0000;
    rbf_clr   = 1'b0;
    case (state)
      S_INIT: begin
        eng_rga  = RGA_SERPER;
        eng_data = INIT_PER;
        if (grant) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (clk7_en) begin
          if (rx_pend)              state_nxt = S_RXRD;
          else if (per_pend)        state_nxt = S_WRPER;
          else if (count != '0)     state_nxt = S_POLL;
        end
      end
      S_WRPER: begin
        eng_rga  = RGA_SERPER;
        eng_data = per_reg;
        if (grant) state_nxt = S_IDLE;
      end
      S_RXRD: begin
        eng_rga = RGA_SERDATR;
        if (grant) state_nxt = S_RXCLR;
      end
      S_RXCLR: begin
        // No bus slot: the clear pulse goes to INTREQ logic, not the UART port.
        rbf_clr = clk7_en;
        if (clk7_en) state_nxt = S_IDLE;
      end
      S_POLL: begin
        eng_rga = RGA_SERDATR;
        if (grant) state_nxt = uart_data_i[13] ? S_WRDAT : S_IDLE;
      end
      S_WRDAT: begin
        eng_rga  = RGA_SERDAT;
        eng_data = {7'b0, 1'b1, fifo_mem[rd_ptr]};
        if (grant) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT_EN ? S_INIT : S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= tx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A new request in the same cycle as the slot that services the old one wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_pend  <= 1'b0;
      per_pend <= 1'b0;
      per_reg  <= 16'h0000;
    end else begin
      if (clk7_en & rxint) rx_pend <= 1'b1;
      else if (rx_take)    rx_pend <= 1'b0;
      if (clk7_en & per_wr) begin
        per_reg  <= per_val;
        per_pend <= 1'b1;
      end else if (per_done) begin
        per_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_take) begin
        if (rx_accept) begin
          rx_byte  <= uart_data_i[7:0];
          rx_valid <= 1'b1;
        end else begin
          rx_overflow <= 1'b1;
        end
      end else if (rx_consume) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
